// File: rtl/fpnew_result_fifo.sv
// Result buffer behind an opgroup: queues {result, status, ext bit, tag} and
// accumulates sticky IEEE exception flags for every entry that retires.

package fpnew_pkg;
  typedef struct packed {
    logic NV;
    logic DZ;
    logic OF;
    logic UF;
    logic NX;
  } status_t;
endpackage

module fpnew_result_fifo #(
  parameter int unsigned Width   = 32,
  parameter int unsigned Depth   = 4,
  parameter type         TagType = logic
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [Width-1:0]         result_i,
  input  fpnew_pkg::status_t       status_i,
  input  logic                     extension_bit_i,
  input  TagType                   tag_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [Width-1:0]         result_o,
  output fpnew_pkg::status_t       status_o,
  output logic                     extension_bit_o,
  output TagType                   tag_o,
  output logic [4:0]               fflags_o,
  input  logic                     fflags_clr_i,
  output logic [$clog2(Depth):0]   usage_o,
  output logic                     busy_o
);

  localparam int unsigned AddrWidth = $clog2(Depth);
  localparam logic [AddrWidth:0] FullCount = (AddrWidth + 1)'(Depth);

  typedef struct packed {
    logic [Width-1:0]   result;
    fpnew_pkg::status_t status;
    logic               ext_bit;
    TagType             tag;
  } entry_t;

  entry_t               mem [Depth];
  entry_t               head;
  logic [AddrWidth-1:0] wr_ptr_q, rd_ptr_q;
  logic [AddrWidth:0]   usage_q;
  logic [4:0]           fflags_q, fflags_d;
  logic                 push, pop;

  // Handshake signals come only from registered occupancy, never from the
  // opposite side's valid/ready, so a full buffer refuses a push even when
  // it pops in the same cycle.
  assign in_ready_o  = (usage_q != FullCount);
  assign out_valid_o = (usage_q != '0);
  assign push        = in_valid_i & in_ready_o & ~flush_i;
  assign pop         = out_valid_o & out_ready_i & ~flush_i;

  assign head            = out_valid_o ? mem[rd_ptr_q] : '0;
  assign result_o        = head.result;
  assign status_o        = head.status;
  assign extension_bit_o = head.ext_bit;
  assign tag_o           = head.tag;

  assign usage_o  = usage_q;
  assign busy_o   = out_valid_o;
  assign fflags_o = fflags_q;

  // A clear and a pop in the same cycle keep the popped flags.
  always_comb begin
    fflags_d = fflags_clr_i ? 5'b0 : fflags_q;
    if (pop) fflags_d = fflags_d | status_o;
  end

  // NOTE: storage has no reset; occupancy alone decides what is valid, so
  // clearing the array would only cost reset fan-out.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr_q] <= '{result:  result_i,
                                 status:  status_i,
                                 ext_bit: extension_bit_i,
                                 tag:     tag_i};
  end

  // NOTE: all state here uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      usage_q  <= '0;
      fflags_q <= '0;
    end else begin
      fflags_q <= fflags_d;
      if (flush_i) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        usage_q  <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + AddrWidth'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + AddrWidth'(1);
        case ({push, pop})
          2'b10:   usage_q <= usage_q + (AddrWidth + 1)'(1);
          2'b01:   usage_q <= usage_q - (AddrWidth + 1)'(1);
          default: usage_q <= usage_q;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fpnew_result_fifo.sv
// Directed bench for fpnew_result_fifo: ordering, full/no-bypass, streaming,
// sticky fflags, flush and reset, checked against a small scoreboard.

module tb_fpnew_result_fifo;

  localparam int Depth = 4;

  typedef struct {
    logic [31:0] result;
    logic [4:0]  status;
    logic [7:0]  tag;
  } sb_entry_t;

  logic               clk = 1'b0;
  logic               rst, flush, in_valid, in_ready, ext_in, out_valid, out_ready;
  logic               ext_out, fflags_clr, busy;
  logic [31:0]        result_in, result_out;
  fpnew_pkg::status_t status_in, status_out;
  logic [7:0]         tag_in, tag_out;
  logic [4:0]         fflags;
  logic [2:0]         usage;

  sb_entry_t sb[$];
  logic [4:0] fflags_m;
  int total = 0;
  int bad = 0;
  int retired;

  always #5 clk = ~clk;

  fpnew_result_fifo #(.Width(32), .Depth(Depth), .TagType(logic [7:0])) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .result_i(result_in), .status_i(status_in),
    .extension_bit_i(ext_in), .tag_i(tag_in),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .result_o(result_out), .status_o(status_out),
    .extension_bit_o(ext_out), .tag_o(tag_out),
    .fflags_o(fflags), .fflags_clr_i(fflags_clr),
    .usage_o(usage), .busy_o(busy)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle, compare visible state with the scoreboard, then advance.
  task automatic cycle(input logic v, input logic r, input logic fl, input logic clr,
                       input logic [31:0] res, input logic [7:0] tg, input logic [4:0] st);
    sb_entry_t e;
    logic do_push, do_pop;
    in_valid = v; out_ready = r; flush = fl; fflags_clr = clr;
    result_in = res; tag_in = tg; status_in = st; ext_in = tg[0];
    check("in_ready", in_ready, sb.size() != Depth);
    check("usage", usage, sb.size());
    check("out_valid", out_valid, sb.size() != 0);
    check("busy", busy, sb.size() != 0);
    check("fflags", fflags, fflags_m);
    if (sb.size() != 0) begin
      check("head_result", result_out, sb[0].result);
      check("head_tag", tag_out, sb[0].tag);
      check("head_status", status_out, sb[0].status);
      check("head_ext", ext_out, sb[0].tag[0]);
    end else begin
      check("empty_result", result_out, 0);
      check("empty_tag", tag_out, 0);
    end
    do_push = v && (sb.size() != Depth) && !fl;
    do_pop  = r && (sb.size() != 0) && !fl;
    fflags_m = (clr ? 5'h00 : fflags_m) | ((do_pop && sb.size() != 0) ? sb[0].status : 5'h00);
    e.result = res; e.status = st; e.tag = tg;
    step();
    if (fl) sb.delete();
    else begin
      if (do_pop) begin void'(sb.pop_front()); retired++; end
      if (do_push) sb.push_back(e);
    end
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 8'h0, 5'h0);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; fflags_clr = 1'b0;
    result_in = '0; tag_in = '0; status_in = '0; ext_in = 1'b0;
    fflags_m = '0; retired = 0;
    step(); step();
    rst = 1'b0;

    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_usage", usage, 0);
    check("rst_busy", busy, 0);
    check("rst_fflags", fflags, 0);
    check("rst_result", result_out, 0);

    // Three pushes with the consumer stalled, then drain in order.
    cycle(1, 0, 0, 0, 32'h3F80_0000, 8'd1, 5'h0);
    cycle(1, 0, 0, 0, 32'h4000_0000, 8'd2, 5'h0);
    cycle(1, 0, 0, 0, 32'h4040_0000, 8'd3, 5'h0);
    in_valid = 1'b0;
    check("fill3_usage", usage, 3);
    check("fill3_head", result_out, 32'h3F80_0000);
    check("fill3_tag", tag_out, 8'd1);
    cycle(0, 1, 0, 0, 32'h0, 8'h0, 5'h0);
    cycle(0, 1, 0, 0, 32'h0, 8'h0, 5'h0);
    check("drain_third", result_out, 32'h4040_0000);
    cycle(0, 1, 0, 0, 32'h0, 8'h0, 5'h0);
    check("drain_usage", usage, 0);

    // Fill to Depth; a same-cycle pop must not let the 5th push through.
    for (int i = 0; i < 4; i++) cycle(1, 0, 0, 0, 32'hA000_0000 + i, 8'd10 + 8'(i), 5'h0);
    check("full_in_ready", in_ready, 0);
    check("full_usage", usage, 4);
    cycle(1, 1, 0, 0, 32'hA000_0004, 8'd14, 5'h0);
    check("nobypass_usage", usage, 3);
    check("nobypass_head", tag_out, 8'd11);
    cycle(1, 0, 0, 0, 32'hA000_0004, 8'd14, 5'h0);
    check("refill_usage", usage, 4);
    for (int i = 0; i < 8; i++)
      cycle(i % 3 != 2, i % 2 == 0, 0, 0, 32'hB000_0000 + i, 8'd20 + 8'(i), 5'h0);
    while (sb.size() != 0) cycle(0, 1, 0, 0, 32'h0, 8'h0, 5'h0);

    // Streaming: after the first cycle exactly one retirement per cycle.
    retired = 0;
    for (int i = 0; i < 20; i++) cycle(1, 1, 0, 0, 32'hC000_0000 + i, 8'd40 + 8'(i), 5'h0);
    check("stream_retired", retired, 19);
    check("stream_tail_tag", tag_out, 8'd59);
    cycle(0, 1, 0, 0, 32'h0, 8'h0, 5'h0);

    // Sticky fflags, then a clear coinciding with a pop.
    cycle(1, 0, 0, 0, 32'h1, 8'd70, 5'h01);
    cycle(1, 0, 0, 0, 32'h2, 8'd71, 5'h05);
    cycle(0, 1, 0, 0, 32'h0, 8'h0, 5'h0);
    cycle(0, 1, 0, 0, 32'h0, 8'h0, 5'h0);
    check("fflags_or", fflags, 5'h05);
    cycle(1, 0, 0, 0, 32'h3, 8'd72, 5'h08);
    cycle(0, 1, 0, 1, 32'h0, 8'h0, 5'h0);
    check("fflags_clr_pop", fflags, 5'h08);

    // Flush with three queued (flagged) entries, a push and a ready consumer.
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, 32'hD000_0000 + i, 8'd80 + 8'(i), 5'h02);
    check("preflush_usage", usage, 3);
    cycle(1, 1, 1, 0, 32'hDEAD_BEEF, 8'h77, 5'h10);
    check("flush_usage", usage, 0);
    check("flush_out_valid", out_valid, 0);
    check("flush_fflags", fflags, 5'h08);
    idle();
    check("flush_push_dropped", out_valid, 0);
    cycle(1, 0, 0, 0, 32'hE000_0000, 8'd90, 5'h0);
    check("postflush_tag", tag_out, 8'd90);
    cycle(0, 1, 0, 0, 32'h0, 8'h0, 5'h0);

    // Reset mid-stream with fflags = 0x10 and two entries buffered.
    cycle(1, 0, 0, 0, 32'hF000_0000, 8'd91, 5'h10);
    cycle(0, 1, 0, 1, 32'h0, 8'h0, 5'h0);
    cycle(1, 0, 0, 0, 32'hF000_0001, 8'd92, 5'h0);
    cycle(1, 0, 0, 0, 32'hF000_0002, 8'd93, 5'h0);
    in_valid = 1'b0;
    check("prerst_fflags", fflags, 5'h10);
    check("prerst_usage", usage, 2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    sb.delete();
    fflags_m = '0;
    check("rst2_in_ready", in_ready, 1);
    check("rst2_out_valid", out_valid, 0);
    check("rst2_usage", usage, 0);
    check("rst2_busy", busy, 0);
    check("rst2_fflags", fflags, 0);
    check("rst2_result", result_out, 0);
    check("rst2_tag", tag_out, 0);
    check("rst2_status", status_out, 0);
    check("rst2_ext", ext_out, 0);
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
